// File: rtl/multicycle_memory_responder_if.sv
// Cache-fill bus between the fill controllers and main memory.
// The master issues requests; the slave returns pipelined read data.
interface multicycle_memory_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  enable;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  busy;

    modport master (
        output enable,
        output wr,
        output addr,
        output data_in,
        input  data_out,
        input  data_valid,
        input  addr_out,
        input  busy
    );

    modport slave (
        input  enable,
        input  wr,
        input  addr,
        input  data_in,
        output data_out,
        output data_valid,
        output addr_out,
        output busy
    );
endinterface

// File: rtl/multicycle_memory_responder.sv
// Word-granular main memory with a fixed-latency pipelined read path.
// Reads snapshot the array when accepted; writes commit at once.
module multicycle_memory_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    multicycle_memory_responder_if.slave  bus
);
    localparam int WORDS = 1 << (ADDR_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    logic [LATENCY-1:0]    r_vld;
    logic [DATA_WIDTH-1:0] r_dat [LATENCY];
    logic [ADDR_WIDTH-1:0] r_adr [LATENCY];

    logic [ADDR_WIDTH-2:0] w_idx;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_unused_addr0;

    assign w_idx          = bus.addr[ADDR_WIDTH-1:1];
    assign w_wr           = bus.enable & bus.wr & ~rst;
    assign w_rd           = bus.enable & ~bus.wr & ~rst;
    assign w_unused_addr0 = bus.addr[0];

    // Array write port; contents survive reset, requests during reset dropped.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= bus.data_in;
        end
    end

    // Read pipeline: stage 0 snapshots the array, later stages shift on valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dat[i] <= '0;
                r_adr[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd;
            if (w_rd) begin
                r_dat[0] <= r_mem[w_idx];
                r_adr[0] <= {bus.addr[ADDR_WIDTH-1:1], 1'b0};
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                    r_adr[i] <= r_adr[i-1];
                end
            end
        end
    end

    assign bus.data_out   = r_dat[LATENCY-1];
    assign bus.addr_out   = r_adr[LATENCY-1];
    assign bus.data_valid = r_vld[LATENCY-1];
    assign bus.busy       = |r_vld;
endmodule

// File: doc/multicycle_memory_responder.md
Name: multicycle_memory_responder

Overview:
- Main-memory end of the cache fill interface: a 64KB byte-addressed, word-granular (2B) memory that answers one request per cycle.
- Read data returns after a fixed pipelined latency (default 4 cycles), with a one-cycle valid strobe and an echo of the request address.
- Writes from the write-through cache commit immediately.
- Sits between the I-/D-cache fill controllers (or their arbiter) and the backing store. Serves as both the synthesizable memory model and the testbench memory.

Parameters:
ADDR_WIDTH, 16, byte-address width; array holds 2^(ADDR_WIDTH-1) 16-bit words
DATA_WIDTH, 16, word width in bits
LATENCY, 4, read latency in cycles; legal values 1..8

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  request present this cycle
wr  input  1  1 = write request, 0 = read request; qualified by enable
addr  input  ADDR_WIDTH  byte address; bit 0 ignored (word aligned)
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  read data; meaningful only while data_valid
data_valid  output  1  one-cycle strobe marking returned read data
addr_out  output  ADDR_WIDTH  address of the read returned this cycle, with bit 0 forced to 0
busy  output  1  high while any read is in flight in the pipeline

Behaviour:
- Request acceptance:
  - A request is sampled at the rising edge ending cycle N, when enable=1.
  - No backpressure: every cycle may carry a request.
- Write (enable=1, wr=1):
  - mem[addr[ADDR_WIDTH-1:1]] <= data_in at edge N.
  - No response, no data_valid.
- Read (enable=1, wr=0):
  - The array word is snapshotted at edge N into pipe stage 1, together with the address and a valid bit.
  - Stages shift one per edge.
  - Stage LATENCY drives data_out, addr_out and data_valid.
  - The read issued in cycle N therefore shows data_valid=1 during cycle N+LATENCY only.
- Snapshot semantics:
  - A write in cycle N+1 .. N+LATENCY-1 to the same address does not alter the in-flight read data.
  - A read issued in the cycle after a write returns the new data.
- Pipelining:
  - Back-to-back reads in cycles N..N+7 return in cycles N+LATENCY..N+LATENCY+7, in order, one word per cycle.
  - Bubbles (enable=0, or write cycles) propagate as data_valid=0 in the same relative position.
- busy = OR of all stage valid bits. It is combinational from the stage registers.
- No internal state machine beyond the valid shift chain. Stage registers hold their values when not valid, but data_valid gates their meaning.
- Reset (asynchronous, any time):
  - All stage valid bits clear, so data_valid=0 and busy=0 immediately.
  - data_out=0 and addr_out=0.
  - In-flight reads are discarded and never return, including after rst deasserts.
  - Memory array contents are NOT reset.
  - Requests presented while rst=1 are ignored, writes included.
- Address boundaries:
  - Address 0xFFFE and address 0x0000 are distinct words. No wrap-around arithmetic inside the block.
  - Odd addresses alias to the even word below, e.g. 0x1235 -> word 0x1234.
- Uninitialized words read as X in simulation. Benches must write before reading.

Test Plan:
- Single read: write 0xBEEF @0x0040 in cycle 0; read @0x0040 in cycle 1 -> data_valid=1 only in cycle 5, data_out=0xBEEF, addr_out=0x0040, busy high in cycles 2-5.
- Block burst: preload words 0x1000..0x100E with 0xA000+index; issue 8 back-to-back reads starting 0x1000 in cycles 10-17 -> data_valid cycles 14-21, data_out 0xA000..0xA007 in order, addr_out stepping by 2.
- Snapshot: mem@0x0200=0x1111; read @0x0200 in cycle 0, write 0x2222 @0x0200 in cycle 1, read @0x0200 in cycle 2 -> returns 0x1111 in cycle 4, then 0x2222 in cycle 6.
- Bubbles and alias: read @0x0301 (mem@0x0300=0x5A5A), idle one cycle, write elsewhere, read @0x0300 -> two strobes, both 0x5A5A, addr_out 0x0300, spaced by the same 2-cycle gap as issued.
- Reset mid-burst: start 8-read burst, assert rst asynchronously in the middle of burst cycle 3 for 1 cycle -> data_valid and busy drop immediately, no strobe ever appears for dropped reads, earlier-written memory contents intact on re-read.
- LATENCY=1 build: read issued in cycle N -> data_valid in cycle N+1; the burst of 8 returns in 8 consecutive cycles.
